cd_cfg_master: RTL and testbench

Configuration-bus initiator that drives the `c_addr`/`c_data`/`c_valid`/`c_ready` port of the clock divider and other configurable blocks. It buffers write requests from the command path (UART command decoder) in a small FIFO and issues them one at a time with a four-phase handshake, because responders such as the clock divider configuration logic run on another clock. It sits between the command decoder and the configuration ports, and reports completion and timeout status.

---
 rtl/cd_cfg_master.sv | 144 ++++++++++++++
 tb/tb_cd_cfg_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_cfg_master.sv
// Configuration-bus initiator: buffers write requests and issues each one
// over a four-phase c_valid/c_ready handshake to a possibly asynchronous responder.
module cd_cfg_master #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter int TIMEOUT           = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req_data,
  output logic                         req_ready,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  input  logic                         err_clr
);

  localparam int AW = WIDTH_CONFIG_ADDR;
  localparam int DW = WIDTH_CONFIG_DATA;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT1 = (PW+1)'(1);
  localparam logic [PW-1:0] PTR1 = PW'(1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIM1 = TW'(1);

  typedef enum logic [1:0] {IDLE, REQ, ACKW} state_t;

  logic [AW+DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;
  logic             push;
  logic             pop;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic             sync1;
  logic             rdy_s;
  state_t           state;
  logic [TW-1:0]    timer;
  logic             tmo;

  assign req_ready = (count != FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (count != '0) || (state != IDLE);
  assign {head_addr, head_data} = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_addr, req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR1;
      if (pop)  rptr <= rptr + PTR1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: ;
      endcase
    end
  end

  // c_ready may come from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      sync1 <= c_ready;
      rdy_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      c_valid     <= 1'b0;
      c_addr      <= '0;
      c_data      <= '0;
      timer       <= '0;
      tmo         <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      // a timeout set later in this block overrides the clear
      if (err_clr) err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            c_addr  <= head_addr;
            c_data  <= head_data;
            c_valid <= 1'b1;
            timer   <= '0;
            tmo     <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (rdy_s) begin
            c_valid <= 1'b0;
            timer   <= '0;
            state   <= ACKW;
          end else if (timer == TMAX) begin
            c_valid     <= 1'b0;
            err_timeout <= 1'b1;
            tmo         <= 1'b1;
            timer       <= '0;
            state       <= ACKW;
          end else begin
            timer <= timer + TIM1;
          end
        end
        ACKW: begin
          if (!rdy_s) begin
            done  <= ~tmo;
            state <= IDLE;
          end else if (timer == TMAX) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TIM1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_cfg_master.sv
// Directed bench for cd_cfg_master: single write, FIFO full/drain,
// REQ and ACKW timeouts, error clear and asynchronous reset mid-request.
module tb_cd_cfg_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic        req_ready;
  logic [3:0]  c_addr;
  logic [15:0] c_data;
  logic        c_valid;
  logic        c_ready;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  cd_cfg_master #(
    .WIDTH_CONFIG_ADDR(4),
    .WIDTH_CONFIG_DATA(16),
    .FIFO_DEPTH(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .c_addr(c_addr),
    .c_data(c_data),
    .c_valid(c_valid),
    .c_ready(c_ready),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // responder that acknowledges as soon as it sees c_valid
  task automatic hs(input logic [3:0] ea, input logic [15:0] ed);
    int n;
    n = 0;
    while (!c_valid && n < 40) begin tick(); n++; end
    chk("hs_valid", 32'(c_valid), 32'd1);
    chk("hs_addr", 32'(c_addr), 32'(ea));
    chk("hs_data", 32'(c_data), 32'(ed));
    c_ready = 1'b1;
    n = 0;
    while (c_valid && n < 40) begin tick(); n++; end
    chk("hs_valid_fall", 32'(c_valid), 32'd0);
    c_ready = 1'b0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("hs_done", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    c_ready   = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    chk("rst_c_valid", 32'(c_valid), 32'd0);
    chk("rst_c_addr", 32'(c_addr), 32'd0);
    chk("rst_c_data", 32'(c_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // single write
    req_valid = 1'b1;
    req_addr  = 4'd1;
    req_data  = 16'h1234;
    tick();
    req_valid = 1'b0;
    chk("sw_push_busy", 32'(busy), 32'd1);
    chk("sw_not_yet_valid", 32'(c_valid), 32'd0);
    tick();
    chk("sw_valid", 32'(c_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("sw_addr_stable", 32'(c_addr), 32'd1);
      chk("sw_data_stable", 32'(c_data), 32'h1234);
      tick();
    end
    c_ready = 1'b1;
    tick();
    chk("sw_valid_e1", 32'(c_valid), 32'd1);
    tick();
    chk("sw_valid_e2", 32'(c_valid), 32'd1);
    tick();
    chk("sw_valid_e3", 32'(c_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("sw_no_early_done", 32'(done), 32'd0);
      tick();
    end
    c_ready = 1'b0;
    tick();
    chk("sw_done_e1", 32'(done), 32'd0);
    tick();
    chk("sw_done_e2", 32'(done), 32'd0);
    tick();
    chk("sw_done_e3", 32'(done), 32'd1);
    chk("sw_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("sw_done_one_cycle", 32'(done), 32'd0);
    chk("sw_addr_kept", 32'(c_addr), 32'd1);

    // FIFO full: 1 in REQ + 4 buffered, push/pop overlap on the 2nd edge
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr = 4'(i + 2);
      req_data = 16'hA000 + 16'(i);
      tick();
      chk("ff_req_ready", 32'(req_ready), (i == 4) ? 32'd0 : 32'd1);
    end
    req_addr = 4'hF;
    req_data = 16'hDEAD;
    tick();
    chk("ff_still_full", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) hs(4'(i + 2), 16'hA000 + 16'(i));
    tick();
    tick();
    chk("ff_drained_busy", 32'(busy), 32'd0);
    chk("ff_no_extra_valid", 32'(c_valid), 32'd0);

    // REQ timeout with a second entry queued behind it
    req_valid = 1'b1;
    req_addr  = 4'd7;
    req_data  = 16'hBEEF;
    tick();
    req_addr  = 4'd8;
    req_data  = 16'h5555;
    tick();
    req_valid = 1'b0;
    chk("rt_valid", 32'(c_valid), 32'd1);
    chk("rt_addr", 32'(c_addr), 32'd7);
    for (int i = 0; i < 14; i++) tick();
    chk("rt_still_valid", 32'(c_valid), 32'd1);
    chk("rt_err_not_yet", 32'(err_timeout), 32'd0);
    tick();
    tick();
    chk("rt_valid_drop", 32'(c_valid), 32'd0);
    chk("rt_err_set", 32'(err_timeout), 32'd1);
    chk("rt_no_done_a", 32'(done), 32'd0);
    tick();
    chk("rt_no_done_b", 32'(done), 32'd0);
    hs(4'd8, 16'h5555);
    chk("rt_err_sticky", 32'(err_timeout), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("rt_err_clr", 32'(err_timeout), 32'd0);

    // ACKW timeout: responder never drops c_ready
    req_valid = 1'b1;
    req_addr  = 4'd3;
    req_data  = 16'h0F0F;
    tick();
    req_valid = 1'b0;
    tick();
    chk("at_valid", 32'(c_valid), 32'd1);
    c_ready = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!err_timeout && n < 60) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk("at_err_set", 32'(err_timeout), 32'd1);
    chk("at_valid_low", 32'(c_valid), 32'd0);
    tick();
    if (done) seen = 1'b1;
    chk("at_no_done", 32'(seen), 32'd0);
    chk("at_idle_busy", 32'(busy), 32'd0);
    c_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("at_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("at_err_clr", 32'(err_timeout), 32'd0);

    // asynchronous reset mid-REQ with two entries queued
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 4'(9 + i);
      req_data = 16'hC000 + 16'(i);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("mr_valid_before", 32'(c_valid), 32'd1);
    chk("mr_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid_async", 32'(c_valid), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_c_addr", 32'(c_addr), 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (c_valid || busy) seen = 1'b1;
    end
    chk("mr_no_issue", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
